// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
    } ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_bubble: 1'b0, pipe_hold: 1'b1};
    localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                      idex_bubble: 1'b1, pipe_hold: 1'b0};
    localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_bubble: 1'b1, pipe_hold: 1'b0};
    localparam ctrl_t CTRL_ADV    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                      idex_bubble: 1'b0, pipe_hold: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in ID/EX whose destination feeds the instruction in IF/ID.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       load_use
);

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = idex_memread && (idex_rt != REG_ZERO) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline with memory-wait watchdog
// and saturating performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             ex_branch_taken,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic              set_error;
    logic              mem_req;
    logic              load_use;
    ctrl_t             ctrl;

    function automatic ctrl_t resolve(input logic branch, input logic hazard);
        if (branch) begin
            return CTRL_FLUSH;
        end else if (hazard) begin
            return CTRL_STALL;
        end
        return CTRL_ADV;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + CNT_W'(1);
    endfunction

    assign mem_req = exmem_memread | exmem_memwrite;

    load_use_detect u_load_use_detect (
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .load_use     (load_use)
    );

    always_comb begin
        ctrl          = CTRL_FREEZE;
        state_next    = state;
        wait_cnt_next = wait_cnt;
        set_error     = 1'b0;
        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end else begin
                    ctrl = resolve(ex_branch_taken, load_use);
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    if (wait_cnt == WAIT_LIMIT) begin
                        state_next = HALT;
                        set_error  = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    // A ready arriving on the limit cycle still completes cleanly.
                    ctrl          = resolve(ex_branch_taken, load_use);
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end
            end
            HALT: begin
                ctrl = CTRL_FREEZE;
            end
            default: begin
                ctrl       = CTRL_FREEZE;
                state_next = RUN;
            end
        endcase
    end

    // Reset overrides the Mealy outputs so the pipeline is quiescent while held.
    assign pc_write    = rst_n & ctrl.pc_write;
    assign ifid_write  = rst_n & ctrl.ifid_write;
    assign ifid_flush  = rst_n & ctrl.ifid_flush;
    assign idex_bubble = rst_n & ctrl.idex_bubble;
    assign pipe_hold   = rst_n & ctrl.pipe_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_error    <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (set_error) begin
                mem_error <= 1'b1;
            end
            if ((state != HALT) && !ctrl.pc_write) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (ctrl.ifid_flush) begin
                flush_count <= sat_inc(flush_count);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed checks of pipeline_hazard_ctrl against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
    logic          idex_memread = 1'b0, ex_branch_taken = 1'b0;
    logic          exmem_memread = 1'b0, exmem_memwrite = 1'b0, mem_ready = 1'b0;
    logic          pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_error;
    logic [CW-1:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model: halted flag, in-access flag, not-ready cycles so far, counters.
    int         m_halt, m_busy, m_nready, m_err, m_stall, m_flush;
    bit         m_frozen;
    logic [4:0] exp_ctrl;

    always #10 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .idex_memread    (idex_memread),
        .idex_rt         (idex_rt),
        .ex_branch_taken (ex_branch_taken),
        .exmem_memread   (exmem_memread),
        .exmem_memwrite  (exmem_memwrite),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .pipe_hold       (pipe_hold),
        .mem_error       (mem_error),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_halt = 0; m_busy = 0; m_nready = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endfunction

    function automatic void model_eval();
        bit dep;
        dep = idex_memread && (idex_rt != 0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        m_frozen = (m_halt != 0) ||
                   (!mem_ready && ((m_busy != 0) || exmem_memread || exmem_memwrite));
        if (m_frozen)             exp_ctrl = 5'b00001;
        else if (ex_branch_taken) exp_ctrl = 5'b11110;
        else if (dep)             exp_ctrl = 5'b00010;
        else                      exp_ctrl = 5'b11000;
    endfunction

    function automatic void model_update();
        if (m_halt == 0 && !exp_ctrl[4]) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (exp_ctrl[2])                 m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        if (m_halt == 0) begin
            if (m_frozen) begin
                m_busy   = 1;
                m_nready = m_nready + 1;
                // Watchdog allows the request cycle plus TO further not-ready cycles.
                if (m_nready > TO) begin
                    m_halt = 1;
                    m_err  = 1;
                end
            end else begin
                m_busy   = 0;
                m_nready = 0;
            end
        end
    endfunction

    task automatic step();
        model_eval();
        #1;
        check("ctrl", {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}, exp_ctrl);
        check("stall_cycles", stall_cycles, m_stall);
        check("flush_count", flush_count, m_flush);
        check("mem_error", mem_error, m_err);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold}, 5'b0);
        check("rst_stall", stall_cycles, 0);
        check("rst_flush", flush_count, 0);
        check("rst_err", mem_error, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                         input logic [4:0] drt, input logic br, input logic emr,
                         input logic emw, input logic rdy);
        ifid_rs = rs; ifid_rt = rt; idex_memread = mr; idex_rt = drt;
        ex_branch_taken = br; exmem_memread = emr; exmem_memwrite = emw; mem_ready = rdy;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Load-use stalls one cycle; a load into r0 does not.
        drive(8, 3, 1, 8, 0, 0, 0, 1); step();
        drive(8, 3, 0, 0, 0, 0, 0, 1); step();
        check("lu_stall_once", stall_cycles, 1);
        drive(0, 0, 1, 0, 0, 0, 0, 1); step();
        check("lu_r0_nostall", stall_cycles, 1);

        // Branch beats load-use.
        do_reset();
        drive(8, 8, 1, 8, 1, 0, 0, 1); step();
        drive(1, 2, 0, 0, 0, 0, 0, 1); step();
        check("br_flush_cnt", flush_count, 1);
        check("br_stall_cnt", stall_cycles, 0);

        // Three not-ready cycles then release.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2, 0, 0, 0, 1, 0, 0); step();
        end
        drive(1, 2, 0, 0, 0, 1, 0, 1); step();
        check("memwait_stall", stall_cycles, 3);
        drive(1, 2, 0, 0, 0, 0, 0, 0); step();
        check("memwait_run", pc_write, 1);

        // Ready on the limit cycle completes without fault.
        do_reset();
        for (int i = 0; i < TO; i++) begin
            drive(1, 2, 0, 0, 0, 0, 1, 0); step();
        end
        drive(1, 2, 0, 0, 0, 0, 1, 1); step();
        check("limit_ready_noerr", mem_error, 0);

        // Timeout into HALT, then reset clears everything.
        do_reset();
        for (int i = 0; i < TO + 4; i++) begin
            drive(1, 2, 0, 0, 0, 1, 0, 0); step();
        end
        check("timeout_err", mem_error, 1);
        check("halt_stall_frozen", stall_cycles, TO + 1);
        drive(8, 8, 1, 8, 1, 0, 0, 1); step();
        do_reset();
        drive(1, 2, 0, 0, 0, 0, 0, 1); step();

        // Saturation of the stall counter.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(9, 1, 1, 9, 0, 0, 0, 1); step();
            drive(9, 1, 0, 0, 0, 0, 0, 1); step();
        end
        check("stall_saturate", stall_cycles, CMAX);

        // Asynchronous reset while waiting on memory.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 2, 0, 0, 0, 1, 0, 0); step();
        end
        do_reset();
        drive(8, 3, 1, 8, 0, 1, 0, 1); step();

        // Randomized traffic with periodic reset.
        for (int n = 0; n < 2000; n++) begin
            bit slow;
            slow = ((n / 40) % 3) == 2;
            drive(pick_reg(), pick_reg(), ($urandom_range(0, 1) == 1), pick_reg(),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 6) == 0),
                  slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 9) < 7));
            if ((n % 97) == 96) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
